// File: rtl/iot_pkg.sv
// Shared definitions for the IoT event arbiter: default device count,
// event-direction encoding and the dev_id width helper.
package iot_pkg;

   localparam int N_DEV_DEFAULT = 8;

   // Direction carried on on_off with each change pulse
   localparam logic EV_ON  = 1'b1;
   localparam logic EV_OFF = 1'b0;

   // Width of a device index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W_DEFAULT = id_width(N_DEV_DEFAULT);

   typedef logic [ID_W_DEFAULT-1:0] dev_id_t;

endpackage

// File: rtl/iot_event_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index at or
// above i_ptr, wrapping from N_DEV-1 to 0. No grant while i_en is low.
module rr_arbiter
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEFAULT,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic [N_DEV-1:0] i_req,
   input  logic             i_en,
   input  logic [ID_W-1:0]  i_ptr,
   output logic             o_gnt_valid,
   output logic [ID_W-1:0]  o_gnt_idx
);

   logic            w_found;
   logic [ID_W-1:0] w_idx;

   // Rotating priority search starting at the pointer
   always_comb begin
      int j;
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_found = 1'b0;
      w_idx   = '0;
      j       = 0;
      for (int k = 0; k < N_DEV; k++) begin
         j = int'(i_ptr) + k;
         if (j >= N_DEV) begin
            j = j - N_DEV;
         end
         if (!w_found && i_req[j]) begin
            w_found = 1'b1;
            w_idx   = ID_W'(j);
         end
      end
   end

   assign o_gnt_valid = w_found & i_en;
   assign o_gnt_idx   = o_gnt_valid ? w_idx : '0;

endmodule

// File: rtl/iot_event_arbiter.sv
// IoT event arbiter: detects per-device on/off edges, holds one unserved
// event per device (a reversal before service cancels it), and issues at most
// one registered change/on_off/dev_id pulse per clock in round-robin order.
// Optional build macro IOT_ARB_SYNC_EN adds a 2-flop synchroniser on every
// dev_status bit ahead of edge detection (input-to-change latency 4 clocks
// instead of 2).
module iot_event_arbiter
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEFAULT,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_DEV-1:0] dev_status,
   input  logic             enable,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic             pending
);

   logic [N_DEV-1:0] w_status;
   logic [N_DEV-1:0] r_status_q;
   logic [N_DEV-1:0] w_rise;
   logic [N_DEV-1:0] w_fall;
   logic [N_DEV-1:0] w_edge;

   logic [N_DEV-1:0] r_pend_v;
   logic [N_DEV-1:0] r_pend_dir;
   logic [N_DEV-1:0] w_pend_v_nxt;
   logic [N_DEV-1:0] w_pend_dir_nxt;

   logic             w_gnt_valid;
   logic [ID_W-1:0]  w_gnt_idx;
   logic [N_DEV-1:0] w_gnt_oh;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  w_ptr_nxt;

   logic             r_change;
   logic             r_on_off;
   logic [ID_W-1:0]  r_dev_id;
   logic             r_pending;

`ifdef IOT_ARB_SYNC_EN
   logic [N_DEV-1:0] r_sync_meta;
   logic [N_DEV-1:0] r_sync_out;

   // Two-stage synchroniser per status bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_meta <= '0;
         r_sync_out  <= '0;
      end else begin
         // NOTE: non-blocking assignments make both stages sample the old
         // values at the same edge, giving a true two-flop chain.
         r_sync_meta <= dev_status;
         r_sync_out  <= r_sync_meta;
      end
   end

   assign w_status = r_sync_out;
`else
   assign w_status = dev_status;
`endif

   // Edges against the previous sample; a zero previous sample after reset
   // makes devices already on show up as on-events.
   assign w_rise = w_status & ~r_status_q;
   assign w_fall = ~w_status & r_status_q;
   assign w_edge = w_rise | w_fall;

   rr_arbiter #(
      .N_DEV (N_DEV),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .i_req       (r_pend_v),
      .i_en        (enable),
      .i_ptr       (r_ptr),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   assign w_gnt_oh  = w_gnt_valid ? (N_DEV'(1) << w_gnt_idx) : '0;
   assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_DEV - 1)) ? '0 : (w_gnt_idx + ID_W'(1));

   // Per-device pending event: serve, replace, cancel on reversal, or hold
   always_comb begin
      w_pend_v_nxt   = r_pend_v;
      w_pend_dir_nxt = r_pend_dir;
      for (int i = 0; i < N_DEV; i++) begin
         if (w_gnt_oh[i]) begin
            // Served this cycle; a same-cycle edge becomes the next event
            w_pend_v_nxt[i] = w_edge[i];
            if (w_edge[i]) begin
               w_pend_dir_nxt[i] = w_rise[i] ? EV_ON : EV_OFF;
            end
         end else if (w_edge[i]) begin
            if (r_pend_v[i]) begin
               // A held event can only be undone by the opposite edge
               w_pend_v_nxt[i] = 1'b0;
            end else begin
               w_pend_v_nxt[i]   = 1'b1;
               w_pend_dir_nxt[i] = w_rise[i] ? EV_ON : EV_OFF;
            end
         end
      end
   end

   // State, pointer and registered event outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the pending flags are ordinary per-device flops, not a RAM,
         // so they are reset so stale events cannot survive a reset.
         r_status_q <= '0;
         r_pend_v   <= '0;
         r_pend_dir <= '0;
         r_ptr      <= '0;
         r_change   <= 1'b0;
         r_on_off   <= 1'b0;
         r_dev_id   <= '0;
         r_pending  <= 1'b0;
      end else begin
         r_status_q <= w_status;
         r_pend_v   <= w_pend_v_nxt;
         r_pend_dir <= w_pend_dir_nxt;
         r_pending  <= |w_pend_v_nxt;
         if (w_gnt_valid) begin
            r_change <= 1'b1;
            r_on_off <= r_pend_dir[w_gnt_idx];
            r_dev_id <= w_gnt_idx;
            r_ptr    <= w_ptr_nxt;
         end else begin
            r_change <= 1'b0;
            r_on_off <= 1'b0;
            r_dev_id <= '0;
         end
      end
   end

   assign change  = r_change;
   assign on_off  = r_on_off;
   assign dev_id  = r_dev_id;
   assign pending = r_pending;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Self-checking bench for iot_event_arbiter (default build, N_DEV=8).
// The reference model tracks, per device, the level last sampled and the
// level last reported to the counter; a device is pending whenever the two
// differ, and the pending direction is the sampled level.
module tb_iot_event_arbiter;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [N-1:0]  dev_status = '0;
   logic          enable = 1'b0;
   logic          change;
   logic          on_off;
   logic [IW-1:0] dev_id;
   logic          pending;

   iot_event_arbiter #(.N_DEV(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dev_status (dev_status),
      .enable     (enable),
      .change     (change),
      .on_off     (on_off),
      .dev_id     (dev_id),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit m_samp [N];
   bit m_rep  [N];
   int m_ptr;
   bit e_change;
   bit e_onoff;
   int e_id;
   bit e_pending;

   // Observed issue log
   int issued_id  [$];
   bit issued_dir [$];
   int issued_cyc [$];
   int cyc;
   int dut_sum;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_samp[i] = 1'b0;
         m_rep[i]  = 1'b0;
      end
      m_ptr     = 0;
      e_change  = 1'b0;
      e_onoff   = 1'b0;
      e_id      = 0;
      e_pending = 1'b0;
   endtask

   task automatic clear_log();
      issued_id.delete();
      issued_dir.delete();
      issued_cyc.delete();
   endtask

   // Model behaviour at one rising edge
   task automatic model_edge();
      int g;
      g = -1;
      if (enable) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && m_samp[j] != m_rep[j]) g = j;
         end
      end
      if (g >= 0) begin
         e_change = 1'b1;
         e_onoff  = m_samp[g];
         e_id     = g;
         m_rep[g] = m_samp[g];
         m_ptr    = (g + 1) % N;
      end else begin
         e_change = 1'b0;
         e_onoff  = 1'b0;
         e_id     = 0;
      end
      e_pending = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_samp[i] = dev_status[i];
         if (m_samp[i] != m_rep[i]) e_pending = 1'b1;
      end
   endtask

   // One clock: advance model, then compare all outputs just after the edge
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      n_checks++;
      if ({change, on_off, dev_id, pending} !== {e_change, e_onoff, IW'(e_id), e_pending}) begin
         n_fail++;
         $display("FAIL cycle %0d: got change=%b on_off=%b dev_id=%0d pending=%b, want change=%b on_off=%b dev_id=%0d pending=%b",
                  cyc, change, on_off, dev_id, pending, e_change, e_onoff, e_id, e_pending);
      end
      if (change === 1'b1) begin
         issued_id.push_back(int'(dev_id));
         issued_dir.push_back(on_off);
         issued_cyc.push_back(cyc);
         dut_sum += (on_off === 1'b1) ? 1 : -1;
      end
   endtask

   task automatic drain(input int max_cycles);
      bit done;
      done = 1'b0;
      for (int k = 0; k < max_cycles; k++) begin
         step();
         if (!e_pending && !e_change) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL drain_timeout: still pending after %0d cycles, want idle", max_cycles);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      n_checks++;
      if ({change, on_off, dev_id, pending} !== '0) begin
         n_fail++;
         $display("FAIL %s: got change=%b on_off=%b dev_id=%0d pending=%b, want all 0",
                  name, change, on_off, dev_id, pending);
      end
   endtask

   // Reset asserted away from the clock edge, released just after a rising edge
   task automatic apply_reset(input logic [N-1:0] status_at_release);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset_async");
      model_reset();
      clear_log();
      dut_sum    = 0;
      dev_status = status_at_release;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      apply_reset(8'b0000_0101);
      for (int k = 0; k < 4; k++) step();
      n_checks++;
      if (issued_id.size() != 2 || issued_id[0] != 0 || issued_id[1] != 2 ||
          issued_dir[0] != 1'b1 || issued_dir[1] != 1'b1 ||
          issued_cyc[0] != 2 || issued_cyc[1] != 3) begin
         n_fail++;
         $display("FAIL reset_release: got %0d issues ids=%p cycs=%p, want ids 0,2 on at cycles 2,3",
                  issued_id.size(), issued_id, issued_cyc);
      end
      n_checks++;
      if (pending !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pending: got %b want 0", pending);
      end
   endtask

   task automatic test_cancel();
      clear_log();
      enable = 1'b0;
      dev_status[3] = 1'b1;
      step();
      step();
      dev_status[3] = 1'b0;
      step();
      step();
      enable = 1'b1;
      for (int k = 0; k < 3; k++) step();
      n_checks++;
      if (issued_id.size() != 0 || pending !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel: got %0d issues pending=%b, want 0 issues pending=0",
                  issued_id.size(), pending);
      end
   endtask

   task automatic test_all_rise();
      enable = 1'b1;
      apply_reset('0);
      step();
      dev_status = '1;
      for (int k = 0; k < 10; k++) step();
      n_checks++;
      if (issued_id.size() != N) begin
         n_fail++;
         $display("FAIL all_rise_count: got %0d want %0d", issued_id.size(), N);
      end else begin
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (issued_id[i] != i || issued_dir[i] != 1'b1 || issued_cyc[i] != issued_cyc[0] + i) begin
               n_fail++;
               $display("FAIL all_rise_%0d: got id=%0d dir=%b cyc=%0d, want id=%0d dir=1 cyc=%0d",
                        i, issued_id[i], issued_dir[i], issued_cyc[i], i, issued_cyc[0] + i);
            end
         end
      end
   endtask

   task automatic test_wrap();
      clear_log();
      dev_status[5] = 1'b0;
      drain(10);
      clear_log();
      dev_status[1] = 1'b0;
      dev_status[6] = 1'b0;
      drain(10);
      n_checks++;
      if (issued_id.size() != 2 || issued_id[0] != 6 || issued_id[1] != 1 ||
          issued_dir[0] != 1'b0 || issued_dir[1] != 1'b0) begin
         n_fail++;
         $display("FAIL wrap_order: got ids=%p dirs=%p, want 6,1 off", issued_id, issued_dir);
      end
   endtask

   task automatic test_enable_toggle();
      int  pattern [4];
      int  seen [N];
      pattern = '{1, 0, 0, 1};
      clear_log();
      enable = 1'b0;
      dev_status[5] = 1'b1;
      dev_status[0] = 1'b0;
      dev_status[3] = 1'b0;
      step();
      step();
      for (int k = 0; k < 4; k++) begin
         enable = pattern[k][0];
         step();
         if (pattern[k] == 0) begin
            n_checks++;
            if (change !== 1'b0) begin
               n_fail++;
               $display("FAIL enable_pause_%0d: got change=%b want 0", k, change);
            end
         end
      end
      enable = 1'b1;
      drain(10);
      for (int i = 0; i < N; i++) seen[i] = 0;
      foreach (issued_id[q]) seen[issued_id[q]]++;
      n_checks++;
      if (issued_id.size() != 3 || seen[0] != 1 || seen[3] != 1 || seen[5] != 1) begin
         n_fail++;
         $display("FAIL enable_toggle: got ids=%p, want 0,3,5 once each", issued_id);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] rel;
      int           seen [N];
      enable = 1'b0;
      dev_status[0] = 1'b1;
      dev_status[1] = 1'b1;
      dev_status[3] = 1'b1;
      dev_status[6] = 1'b1;
      step();
      step();
      enable = 1'b1;
      step();
      rel = N'($urandom);
      apply_reset(rel);
      drain(12);
      for (int i = 0; i < N; i++) seen[i] = 0;
      foreach (issued_id[q]) begin
         seen[issued_id[q]]++;
         n_checks++;
         if (issued_dir[q] != 1'b1 || rel[issued_id[q]] != 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_issue: got id=%0d dir=%b, want on-event of a device that is on",
                     issued_id[q], issued_dir[q]);
         end
      end
      n_checks++;
      if (issued_id.size() != $countones(rel)) begin
         n_fail++;
         $display("FAIL reset_mid_count: got %0d want %0d", issued_id.size(), $countones(rel));
      end
   endtask

   task automatic test_random();
      int exp_sum;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) dev_status[i] = ~dev_status[i];
         end
         enable = ($urandom_range(0, 3) != 0);
         step();
      end
      enable = 1'b1;
      drain(20);
      exp_sum = $countones(dev_status);
      n_checks++;
      if (dut_sum != exp_sum) begin
         n_fail++;
         $display("FAIL random_balance: got issued sum %0d want %0d", dut_sum, exp_sum);
      end
   endtask

   initial begin
      model_reset();
      cyc     = 0;
      dut_sum = 0;
      test_reset();
      test_cancel();
      test_all_rise();
      test_wrap();
      test_enable_toggle();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
- Upstream feeder for the active-IoT-device counter.
- Watches N per-device on/off status lines and detects connect/disconnect edges.
- Holds each device's unserved event, then serialises events round-robin into at most one single-cycle change/on_off pulse per clock.
- The counter consumes those pulses directly, with no handshake.

Parameters:
- N_DEV, 8, number of monitored devices (2..32).
- ID_W, $clog2(N_DEV), width of dev_id.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset. Asserts immediately; deasserts synchronously to clk upstream.
- dev_status  input  N_DEV  per-device level: 1 = device on/connected.
- enable  input  1  1 = may issue events; 0 = hold all pending events.
- change  output  1  registered; 1 for one cycle per issued event.
- on_off  output  1  registered; 1 = device turned on, 0 = device turned off. Valid only when change=1, else driven 0.
- dev_id  output  ID_W  registered; index of the device whose event is issued. Valid with change, else 0.
- pending  output  1  registered; 1 if any device holds an unserved event.

Behaviour:
- Reset (rst_n=0, async):
  - change, on_off, dev_id and pending = 0.
  - status_q (previous-sample register) = 0.
  - Per-device pend_v = 0 and pend_dir = 0.
  - Round-robin pointer = 0.
  - Devices already on at reset release are therefore reported as on-events, consistent with a counter reset to zero.
- Edge detect, per device i, each posedge:
  - rise_i = dev_status[i] & ~status_q[i]; fall_i = ~dev_status[i] & status_q[i].
  - Then status_q <= dev_status.
- Pending update, per device i, each posedge:
  - Granted this cycle and edge present: pend_v=1, pend_dir=rise_i (new event replaces the served one).
  - Granted, no edge: pend_v=0.
  - Not granted, pend_v=0, edge: pend_v=1, pend_dir=rise_i.
  - Not granted, pend_v=1, edge: the edge is necessarily opposite to pend_dir, so cancel (pend_v=0). A net-zero glitch is never reported.
  - Otherwise hold.
- Arbitration:
  - When enable=1 and any pend_v=1, grant exactly one device: the first pending index searching from ptr upward, wrapping at N_DEV-1 to 0.
  - At that posedge: change<=1, on_off<=pend_dir[g], dev_id<=g, ptr<=(g+1) mod N_DEV.
  - Otherwise change<=0, on_off<=0, dev_id<=0, ptr held.
- pending <= OR of next-state pend_v.
- Latency:
  - dev_status changes before posedge k → pending set at k → change visible after posedge k+1.
  - Minimum 1 cycle from pending set to issue; 2 clocks input-to-change.
- Throughput: one event per cycle. N simultaneous edges drain in N consecutive cycles in round-robin order.
- enable=0: no grants. Pending events and the pointer are held. Cancellation still applies.
- Events are never lost except by cancellation.
- Consistency invariant: the sum of issued (+1 on, -1 off) equals popcount(status_q) minus the number of pending on-events plus the number of pending off-events.
- Reset mid-operation: all pending events are discarded; outputs drop to 0 asynchronously.

Optional Feature:
- Macro: IOT_ARB_SYNC_EN.
- Defined: dev_status passes through a 2-flop synchroniser per bit (flops reset to 0) before edge detection. Input-to-change latency becomes 4 clocks; all other behaviour is unchanged.
- Undefined: dev_status is sampled directly and must already be synchronous to clk.

Decomposition:
- Package iot_pkg holds:
  - constant N_DEV_DEFAULT=8.
  - constants EV_ON=1'b1 and EV_OFF=1'b0.
  - function clog2-based ID_W helper.
  - typedef dev_id_t.
- One sub-module, rr_arbiter, is natural:
  - Inputs: req[N_DEV], en, ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational.
- Pointer update and registered outputs stay in iot_event_arbiter.

Test Plan:
- Reset release with dev_status=8'b0000_0101, enable=1:
  - change pulses in cycles 2 and 3 after release.
  - dev_id=0 then 2, on_off=1 both times.
  - pending=0 afterwards.
- Device 3 goes 0→1, then 1→0 two clocks later with enable=0:
  - Event is cancelled; no change pulse after enable=1.
  - pending returns to 0.
- All 8 devices rise in the same cycle, enable=1:
  - 8 consecutive change cycles with dev_id 0..7 and on_off=1.
  - No gaps or repeats.
- Device 5 issued last (ptr=6); devices 1 and 6 pend simultaneously:
  - Order is dev_id=6 then 1 (wrap-around).
- enable toggles 1,0,0,1 while 3 events are pending:
  - Issue pauses during the 0 cycles.
  - All 3 events eventually issue exactly once.
- rst_n asserted mid-drain with 4 events pending:
  - change drops to 0 immediately.
  - After release, events are issued only for devices whose dev_status=1, all with on_off=1.
